// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch channel.
//
// Signals:
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : word-aligned fetch address
//   imem_ack   : memory returns imem_rdata in this cycle
//   imem_rdata : 32-bit instruction word
//
// Modports:
//   master : fetch sequencer side (drives req/addr)
//   slave  : instruction memory side (drives ack/rdata)
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing stage.
//
// Fetches 32-bit words over the imem req/ack channel into the instruction
// register, presents opcode/funct to the control decoder for one decode
// window (ir_valid), then uses Jump/Branch/zero to select the next PC.
//
// Ports:
//   clk         : system clock, rising edge
//   clr         : asynchronous active-low reset
//   imem        : fetch channel (master modport of fetch_sequencer_if)
//   instruction : ir[31:26], opcode to control
//   funct       : ir[5:0]
//   ir          : full instruction register
//   ir_valid    : decode window active, control inputs sampled this cycle
//   pc          : current PC
//   Branch      : conditional branch request from control
//   Jump        : unconditional jump request from control (beats Branch)
//   zero        : ALU zero flag, valid during ir_valid
//   stall       : hold the decode window
//   fetch_err   : sticky fetch timeout flag
//
// Build option:
//   FETCH_TIMEOUT_EN : when defined, a fetch left unacknowledged for
//                      TIMEOUT_CYC cycles sets fetch_err and parks the block
//                      in S_HALT. When undefined, fetch waits forever and
//                      fetch_err is tied 0.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, no request; leaves on the first clock edge
// FETCH | imem_req=1 at imem_addr=pc, waiting for imem_ack
// ISSUE | ir_valid=1, decode window; advances pc unless stalled
// HALT  | fetch timed out; exits only through reset
module fetch_sequencer #(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              clr,
    fetch_sequencer_if.master imem,
    output logic [5:0]        instruction,
    output logic [5:0]        funct,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              zero,
    input  logic              stall,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state;
    logic              req_q;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] pc_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
`endif

    // Address is the PC itself so it is valid and stable for the whole fetch.
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req_q;
    assign instruction    = ir[31:26];
    assign funct          = ir[5:0];

    // Next-PC selection; only consumed in S_ISSUE when not stalled.
    always_comb begin
        pc4     = pc + ADDR_W'(4);
        br_off  = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
        pc_next = pc4;
        if (Jump) begin
            pc_next = {pc4[ADDR_W-1 -: 4], ir[25:0], 2'b00};
        end else if (Branch && zero) begin
            pc_next = pc4 + br_off;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            req_q    <= 1'b0;
            ir_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end

                S_FETCH: begin
                    if (imem.imem_ack) begin
                        // An ack on the last allowed cycle still wins over timeout.
                        ir       <= imem.imem_rdata;
                        state    <= S_ISSUE;
                        req_q    <= 1'b0;
                        ir_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // pc is left pointing at the faulting fetch address.
                        err_q <= 1'b1;
                        state <= S_HALT;
                        req_q <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end

                S_ISSUE: begin
                    if (!stall) begin
                        pc       <= pc_next;
                        state    <= S_FETCH;
                        req_q    <= 1'b1;
                        ir_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end

                S_HALT: begin
                    req_q    <= 1'b0;
                    ir_valid <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    req_q    <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    // Timeout limit has no function in this build.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign fetch_err      = 1'b0;
`endif

endmodule
